// File: rtl/pixel_frame_receiver.sv
// Receiver for the two-wire LED-array link: oversamples SCLK/DIN, rebuilds LSB-first bytes,
// and commits a command byte plus FRAME_BYTES pixel bytes only when a frame ends cleanly.
module pixel_frame_receiver #(
    parameter int FRAME_BYTES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_SCLK,
    input  logic       i_DIN,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic [4:0] o_byte_index,
    output logic [7:0] o_cmd,
    output logic       o_frame_done,
    output logic       o_frame_error,
    input  logic [3:0] i_rd_addr,
    output logic [7:0] o_rd_data
);

    localparam logic [4:0] FULL_COUNT = 5'(FRAME_BYTES + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t state_reg, state_next;

    logic sclk_meta_reg, sclk_s_reg, sclk_p_reg;
    logic din_meta_reg, din_s_reg, din_p_reg;
    logic sclk_rise, link_start, link_stop;
    logic rise_reg, start_reg, stop_reg, din_bit_reg;

    logic [2:0] bit_cnt_reg;
    logic [4:0] byte_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] cmd_shadow_reg;

    logic       restart, shift_en, byte_done;
    logic       frame_done_next, frame_error_next;
    logic [7:0] byte_value;

    logic [7:0] frame_buf [FRAME_BYTES];

    // Synchronizers and history registers idle high, matching the link's idle level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_meta_reg <= 1'b1;
            sclk_s_reg    <= 1'b1;
            sclk_p_reg    <= 1'b1;
            din_meta_reg  <= 1'b1;
            din_s_reg     <= 1'b1;
            din_p_reg     <= 1'b1;
        end else begin
            sclk_meta_reg <= i_SCLK;
            sclk_s_reg    <= sclk_meta_reg;
            sclk_p_reg    <= sclk_s_reg;
            din_meta_reg  <= i_DIN;
            din_s_reg     <= din_meta_reg;
            din_p_reg     <= din_s_reg;
        end
    end

    // Start/stop require SCLK high in both samples, so an SCLK rise always wins over a DIN change.
    assign sclk_rise  = sclk_s_reg & ~sclk_p_reg;
    assign link_start = sclk_s_reg & sclk_p_reg & din_p_reg & ~din_s_reg;
    assign link_stop  = sclk_s_reg & sclk_p_reg & ~din_p_reg & din_s_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rise_reg    <= 1'b0;
            start_reg   <= 1'b0;
            stop_reg    <= 1'b0;
            din_bit_reg <= 1'b0;
        end else begin
            rise_reg    <= sclk_rise;
            start_reg   <= link_start;
            stop_reg    <= link_stop;
            din_bit_reg <= din_s_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        restart          = 1'b0;
        shift_en         = 1'b0;
        frame_done_next  = 1'b0;
        frame_error_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_reg) begin
                    state_next = RECV;
                    restart    = 1'b1;
                end
            end
            RECV: begin
                if (start_reg) begin
                    restart          = 1'b1;
                    frame_error_next = (bit_cnt_reg != 3'd0) || (byte_cnt_reg != 5'd0);
                end else if (stop_reg) begin
                    state_next = IDLE;
                    if ((bit_cnt_reg == 3'd0) && (byte_cnt_reg == FULL_COUNT)) begin
                        frame_done_next = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end else if (rise_reg) begin
                    shift_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign byte_value = {din_bit_reg, shift_reg[7:1]};
    assign byte_done  = shift_en && (bit_cnt_reg == 3'd7);

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt_reg    <= 3'd0;
            byte_cnt_reg   <= 5'd0;
            shift_reg      <= 8'h00;
            cmd_shadow_reg <= 8'h00;
            o_byte         <= 8'h00;
            o_byte_valid   <= 1'b0;
            o_byte_index   <= 5'd0;
            o_cmd          <= 8'h00;
            o_frame_done   <= 1'b0;
            o_frame_error  <= 1'b0;
        end else begin
            o_byte_valid  <= byte_done;
            o_frame_done  <= frame_done_next;
            o_frame_error <= frame_error_next;
            if (restart) begin
                bit_cnt_reg  <= 3'd0;
                byte_cnt_reg <= 5'd0;
                shift_reg    <= 8'h00;
            end else if (shift_en) begin
                shift_reg   <= byte_value;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (byte_done) begin
                    o_byte       <= byte_value;
                    o_byte_index <= byte_cnt_reg;
                    if (byte_cnt_reg != 5'd31) begin
                        byte_cnt_reg <= byte_cnt_reg + 5'd1;
                    end
                    if (byte_cnt_reg == 5'd0) begin
                        cmd_shadow_reg <= byte_value;
                    end
                end
            end
            if (frame_done_next) begin
                o_cmd <= cmd_shadow_reg;
            end
        end
    end

    // Each pixel byte has a shadow slot and a committed slot; commit copies all slots at once.
    generate
        for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_frame
            logic [7:0] shadow_reg;
            logic [7:0] frame_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    shadow_reg <= 8'h00;
                    frame_reg  <= 8'h00;
                end else begin
                    if (byte_done && (byte_cnt_reg == 5'(gi + 1))) begin
                        shadow_reg <= byte_value;
                    end
                    if (frame_done_next) begin
                        frame_reg <= shadow_reg;
                    end
                end
            end

            assign frame_buf[gi] = frame_reg;
        end
    endgenerate

    assign o_rd_data = frame_buf[i_rd_addr];

endmodule
